// File: rtl/imem_boot_loader.sv
// Boot sequencer for cpuCore: streams a program into instruction memory through
// the debug write port, holding the core in reset until a settle window expires.
module imem_boot_loader #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN / 2,
  parameter int MAX_WORDS          = 256,
  parameter int RELEASE_DELAY      = 4,
  parameter int CW                 = $clog2(MAX_WORDS + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [XLEN-1:0]               i_base_addr,
  input  logic [CW-1:0]                 i_word_count,
  input  logic                          i_abort,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [INSTRUCTION_LENGTH-1:0] i_in_instr,
  output logic                          o_dbg_wr_en,
  output logic [XLEN-1:0]               o_dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] o_dbg_instr,
  output logic                          o_core_rst,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error
);

  localparam int SW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } state_t;

  state_t                        r_state;
  logic [XLEN-1:0]               r_base;
  logic [CW-1:0]                 r_count;
  logic [CW-1:0]                 r_idx;
  logic [SW-1:0]                 r_settle;
  logic                          r_in_ready;
  logic                          r_dbg_wr_en;
  logic [XLEN-1:0]               r_dbg_addr;
  logic [INSTRUCTION_LENGTH-1:0] r_dbg_instr;
  logic                          r_core_rst;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_error;

  state_t                        w_state_nxt;
  logic [XLEN-1:0]               w_base_nxt;
  logic [CW-1:0]                 w_count_nxt;
  logic [CW-1:0]                 w_idx_nxt;
  logic [SW-1:0]                 w_settle_nxt;
  logic [XLEN-1:0]               w_addr_nxt;
  logic [INSTRUCTION_LENGTH-1:0] w_instr_nxt;
  logic                          w_error_nxt;
  logic                          w_in_ready_nxt;
  logic                          w_wr_en_nxt;
  logic                          w_busy_nxt;
  logic                          w_core_rst_nxt;
  logic                          w_done_nxt;
  logic                          w_start_legal;
  logic [CW-1:0]                 w_idx_inc;
  logic [XLEN-1:0]               w_wr_addr;

  assign w_start_legal = (i_word_count != {CW{1'b0}}) &&
                         (i_word_count <= CW'(MAX_WORDS));
  assign w_idx_inc     = r_idx + {{(CW-1){1'b0}}, 1'b1};
  // Address arithmetic is modulo 2^XLEN so a high base wraps to zero.
  assign w_wr_addr     = r_base + XLEN'(r_idx);

  // Next-state, datapath capture and error pulse decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_base_nxt   = r_base;
    w_count_nxt  = r_count;
    w_idx_nxt    = r_idx;
    w_settle_nxt = r_settle;
    w_addr_nxt   = r_dbg_addr;
    w_instr_nxt  = r_dbg_instr;
    w_error_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (i_start) begin
          if (w_start_legal) begin
            w_base_nxt  = i_base_addr;
            w_count_nxt = i_word_count;
            w_idx_nxt   = {CW{1'b0}};
            w_state_nxt = ST_LOAD;
          end else begin
            w_error_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOAD: begin
        if (i_abort) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (i_in_valid && r_in_ready) begin
          w_instr_nxt = i_in_instr;
          w_addr_nxt  = w_wr_addr;
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_WRITE: begin
        w_idx_nxt = w_idx_inc;
        if (i_abort) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_idx_inc == r_count) begin
          w_settle_nxt = {SW{1'b0}};
          w_state_nxt  = ST_SETTLE;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (i_abort) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_settle == SW'(RELEASE_DELAY - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_settle_nxt = r_settle + {{(SW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  assign w_in_ready_nxt = (w_state_nxt == ST_LOAD);
  assign w_wr_en_nxt    = (w_state_nxt == ST_WRITE);
  assign w_busy_nxt     = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_WRITE) ||
                          (w_state_nxt == ST_SETTLE);
  assign w_core_rst_nxt = (w_state_nxt != ST_RUN);
  assign w_done_nxt     = (w_state_nxt == ST_RUN) && (r_state != ST_RUN);

  // State, control and registered output flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_base      <= {XLEN{1'b0}};
      r_count     <= {CW{1'b0}};
      r_idx       <= {CW{1'b0}};
      r_settle    <= {SW{1'b0}};
      r_in_ready  <= 1'b0;
      r_dbg_wr_en <= 1'b0;
      r_dbg_addr  <= {XLEN{1'b0}};
      r_dbg_instr <= {INSTRUCTION_LENGTH{1'b0}};
      r_core_rst  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_count     <= w_count_nxt;
      r_idx       <= w_idx_nxt;
      r_settle    <= w_settle_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_dbg_wr_en <= w_wr_en_nxt;
      r_dbg_addr  <= w_addr_nxt;
      r_dbg_instr <= w_instr_nxt;
      r_core_rst  <= w_core_rst_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_dbg_wr_en = r_dbg_wr_en;
  assign o_dbg_addr  = r_dbg_addr;
  assign o_dbg_instr = r_dbg_instr;
  assign o_core_rst  = r_core_rst;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule
